// File: rtl/vga_timing_pkg.sv
// Default 1024x768 raster timing, derived totals/sync windows and coordinate field widths.
// Pure constants: no latency, no backpressure.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 1024;
    localparam int DEF_H_FP     = 24;
    localparam int DEF_H_SYNC   = 136;
    localparam int DEF_H_BP     = 160;
    localparam int DEF_V_ACTIVE = 768;
    localparam int DEF_V_FP     = 3;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BP     = 29;

    localparam int DEF_H_TOTAL     = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL     = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_HSYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_HSYNC_END   = DEF_HSYNC_START + DEF_H_SYNC;
    localparam int DEF_VSYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_VSYNC_END   = DEF_VSYNC_START + DEF_V_SYNC;

    // Split-field widths let consumers tap 32-pixel cells and 64-line bands directly.
    localparam int X_LO_W  = 5;
    localparam int X_HI_W  = 6;
    localparam int Y_LO_W  = 6;
    localparam int Y_HI_W  = 5;
    localparam int COORD_W = X_LO_W + X_HI_W;

endpackage

// File: rtl/vga_split_counter.sv
// Low field with carry into high field, wrapping to zero after the terminal count.
// Advances one step per cycle when inc is high; next-state value exposed combinationally; no backpressure.
module vga_split_counter #(
    parameter int LO_W = 5,
    parameter int HI_W = 6,
    parameter int TERM = 1343
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inc,
    output logic [LO_W-1:0]        lo,
    output logic [HI_W-1:0]        hi,
    output logic [LO_W+HI_W-1:0]   cnt_nxt,
    output logic                   wrap
);

    localparam int              W      = LO_W + HI_W;
    localparam logic [W-1:0]    TERM_V = W'(TERM);

    logic [LO_W-1:0] lo_q, lo_d;
    logic [HI_W-1:0] hi_q, hi_d;
    logic            at_term;

    assign at_term = ({hi_q, lo_q} == TERM_V);
    assign wrap    = inc & at_term;

    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (inc) begin
            if (at_term) begin
                lo_d = '0;
                hi_d = '0;
            end else if (&lo_q) begin
                lo_d = '0;
                hi_d = hi_q + HI_W'(1);
            end else begin
                lo_d = lo_q + LO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign lo      = lo_q;
    assign hi      = hi_q;
    assign cnt_nxt = {hi_d, lo_d};

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: split x/y coordinates, hsync/vsync/blank and a sticky vblank interrupt.
// Zero relative latency (outputs registered from next-state counters); free-running, no backpressure. VGA_SYNC_LINE_IRQ_EN adds irq_line.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cli,
    output logic              hsync,
    output logic              vsync,
    output logic              blank,
    output logic              interrupt,
    output logic [X_LO_W-1:0] x_lo,
    output logic [X_HI_W-1:0] x_hi,
    output logic [Y_LO_W-1:0] y_lo,
    output logic [Y_HI_W-1:0] y_hi
`ifdef VGA_SYNC_LINE_IRQ_EN
    ,
    input  logic [9:0]        irq_line
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_BEG_C = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END_C = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEG_C = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END_C = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    // x_lo wraps at 32, so a line that is not a whole number of cells cannot be split cleanly.
    if ((H_TOTAL % 32) != 0) begin : g_htotal_chk
        $error("vga_sync_gen: H_TOTAL must be a multiple of 32");
    end

    logic [COORD_W-1:0] x_nxt, y_nxt;
    logic               x_wrap;
    logic               y_wrap_unused;

    vga_split_counter #(
        .LO_W (X_LO_W),
        .HI_W (X_HI_W),
        .TERM (H_TOTAL - 1)
    ) u_x_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (1'b1),
        .lo      (x_lo),
        .hi      (x_hi),
        .cnt_nxt (x_nxt),
        .wrap    (x_wrap)
    );

    vga_split_counter #(
        .LO_W (Y_LO_W),
        .HI_W (Y_HI_W),
        .TERM (V_TOTAL - 1)
    ) u_y_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (x_wrap),
        .lo      (y_lo),
        .hi      (y_hi),
        .cnt_nxt (y_nxt),
        .wrap    (y_wrap_unused)
    );

    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic blank_q, blank_d;
    logic int_q,   int_d;
    logic set_evt;

    always_comb begin
        blank_d = (x_nxt >= H_ACT_C) || (y_nxt >= V_ACT_C);
        hsync_d = ((x_nxt >= HS_BEG_C) && (x_nxt < HS_END_C)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d = ((y_nxt >= VS_BEG_C) && (y_nxt < VS_END_C)) ? VSYNC_POL : ~VSYNC_POL;

        set_evt = (x_nxt == '0) && (y_nxt == V_ACT_C);
`ifdef VGA_SYNC_LINE_IRQ_EN
        set_evt = set_evt | ((x_nxt == '0) && (y_nxt == COORD_W'(irq_line)));
`endif
        // A set event on the same edge as cli keeps the interrupt pending.
        int_d = set_evt | (int_q & ~cli);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q <= ~HSYNC_POL;
            vsync_q <= ~VSYNC_POL;
            blank_q <= 1'b0;
            int_q   <= 1'b0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            blank_q <= blank_d;
            int_q   <= int_d;
        end
    end

    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign blank     = blank_q;
    assign interrupt = int_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing instance for line checks, reduced-timing instance for frame/interrupt checks.
module tb_vga_sync_gen;

    logic clk;
    logic rst;
    logic cli;
`ifdef VGA_SYNC_LINE_IRQ_EN
    logic [9:0] irq_line;
`endif

    logic [4:0] b_x_lo, s_x_lo;
    logic [5:0] b_x_hi, s_x_hi;
    logic [5:0] b_y_lo, s_y_lo;
    logic [4:0] b_y_hi, s_y_hi;
    logic b_hsync, b_vsync, b_blank, b_int;
    logic s_hsync, s_vsync, s_blank, s_int;

    logic [25:0] obs_b, obs_s;
    assign obs_b = {b_x_hi, b_x_lo, b_y_hi, b_y_lo, b_hsync, b_vsync, b_blank, b_int};
    assign obs_s = {s_x_hi, s_x_lo, s_y_hi, s_y_lo, s_hsync, s_vsync, s_blank, s_int};

    vga_sync_gen dut_b (
        .clk       (clk),
        .rst       (rst),
        .cli       (cli),
        .hsync     (b_hsync),
        .vsync     (b_vsync),
        .blank     (b_blank),
        .interrupt (b_int),
        .x_lo      (b_x_lo),
        .x_hi      (b_x_hi),
        .y_lo      (b_y_lo),
        .y_hi      (b_y_hi)
`ifdef VGA_SYNC_LINE_IRQ_EN
        ,
        .irq_line  (irq_line)
`endif
    );

    // Small frame: 64 clocks per line, 74 lines, so the frame is 4736 clocks.
    vga_sync_gen #(
        .H_ACTIVE (32), .H_FP (8), .H_SYNC (8), .H_BP (16),
        .V_ACTIVE (66), .V_FP (2), .V_SYNC (3), .V_BP (3)
    ) dut_s (
        .clk       (clk),
        .rst       (rst),
        .cli       (cli),
        .hsync     (s_hsync),
        .vsync     (s_vsync),
        .blank     (s_blank),
        .interrupt (s_int),
        .x_lo      (s_x_lo),
        .x_hi      (s_x_hi),
        .y_lo      (s_y_lo),
        .y_hi      (s_y_hi)
`ifdef VGA_SYNC_LINE_IRQ_EN
        ,
        .irq_line  (irq_line)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [25:0] exp_vec(input int x, input int y, input logic intr,
                                            input int ha, input int hfp, input int hsw,
                                            input int va, input int vfp, input int vsw);
        logic hs, vs, bl;
        bl = (x >= ha) || (y >= va);
        hs = !((x >= ha + hfp) && (x < ha + hfp + hsw));
        vs = (y >= va + vfp) && (y < va + vfp + vsw);
        return {11'(x), 11'(y), hs, vs, bl, intr};
    endfunction

    task automatic adv(inout int x, inout int y, inout logic intr,
                       input int ht, input int vt, input int va, input int line, input logic cl);
        logic set;
        x++;
        if (x == ht) begin
            x = 0;
            y++;
            if (y == vt) y = 0;
        end
        set  = (x == 0) && ((y == va) || (y == line));
        intr = set || (intr && !cl);
    endtask

    // Scoreboard: model steps on every clock edge and queues what each DUT must present.
    logic [25:0] sb_b[$];
    logic [25:0] sb_s[$];
    int   bx = 0, by = 0, sx = 0, sy = 0;
    logic bint = 1'b0, sint = 1'b0;

    initial begin
        int line;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                bx = 0; by = 0; bint = 1'b0;
                sx = 0; sy = 0; sint = 1'b0;
                sb_b.delete();
                sb_s.delete();
            end else begin
`ifdef VGA_SYNC_LINE_IRQ_EN
                line = int'(irq_line);
`else
                line = -1;
`endif
                adv(bx, by, bint, 1344, 806, 768, line, cli);
                adv(sx, sy, sint, 64, 74, 66, line, cli);
                sb_b.push_back(exp_vec(bx, by, bint, 1024, 24, 136, 768, 3, 6));
                sb_s.push_back(exp_vec(sx, sy, sint, 32, 8, 8, 66, 2, 3));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && sb_b.size() > 0) check("cycle_big", 32'(obs_b), 32'(sb_b.pop_front()));
            if (!rst && sb_s.size() > 0) check("cycle_small", 32'(obs_s), 32'(sb_s.pop_front()));
        end
    end

    localparam logic [25:0] RST_VEC = 26'h8;   // x=0 y=0 hsync=1 vsync=0 blank=0 int=0
    localparam int FR    = 4736;
    localparam int F2    = 2 * FR;
    localparam int N_CYC = F2 + 4250;

    initial begin
        int hs_low, hs_first, bl_cnt, bl_first, xhi_chg, vs_cnt, vs_first, vs_second;
        logic [5:0] prev_xhi;
        logic       prev_vs;

        rst = 1'b1;
        cli = 1'b0;
`ifdef VGA_SYNC_LINE_IRQ_EN
        irq_line = 10'd10;
`endif
        repeat (3) @(negedge clk);
        #1;
        check("reset_big", 32'(obs_b), 32'(RST_VEC));
        check("reset_small", 32'(obs_s), 32'(RST_VEC));
        rst = 1'b0;

        repeat (500) @(posedge clk);
        #2;
        check("x_before_reset", 32'({b_x_hi, b_x_lo}), 32'd500);
        rst = 1'b1;
        #1;
        check("midline_reset_big", 32'(obs_b), 32'(RST_VEC));
        check("midline_reset_small", 32'(obs_s), 32'(RST_VEC));

        @(negedge clk);
        #1;
        rst = 1'b0;

        hs_low = 0; hs_first = -1; bl_cnt = 0; bl_first = -1; xhi_chg = 0;
        vs_cnt = 0; vs_first = -1; vs_second = -1;
        prev_xhi = 6'd0; prev_vs = 1'b0;

        for (int k = 0; k < N_CYC; k++) begin
            if (k < 1344) begin
                if (!b_hsync) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = k;
                end
                if (b_blank) begin
                    bl_cnt++;
                    if (bl_first < 0) bl_first = k;
                end
                if (b_x_hi != prev_xhi) xhi_chg++;
                prev_xhi = b_x_hi;
            end
            if (k == 1344) begin
                check("hsync_low_clocks", 32'(hs_low), 32'd136);
                check("hsync_first_x", 32'(hs_first), 32'd1048);
                check("blank_clocks", 32'(bl_cnt), 32'd320);
                check("blank_first_x", 32'(bl_first), 32'd1024);
                check("x_hi_carries", 32'(xhi_chg), 32'd41);
                check("line_wrap_xy", 32'({b_x_hi, b_x_lo, b_y_hi, b_y_lo}), 32'({11'd0, 11'd1}));
            end

            if (k < FR && s_vsync) vs_cnt++;
            if (s_vsync && !prev_vs) begin
                if (vs_first < 0) vs_first = k;
                else if (vs_second < 0) vs_second = k;
            end
            prev_vs = s_vsync;

            case (k)
                64 * 64:  check("small_y_carry", 32'({s_y_hi, s_y_lo}), 32'd64);
                FR:       check("small_frame_wrap", 32'({s_x_hi, s_x_lo, s_y_hi, s_y_lo}), 32'd0);
                FR + 1:   begin
                    check("vsync_clocks", 32'(vs_cnt), 32'd192);
                    check("vsync_first", 32'(vs_first), 32'd4352);
                end
`ifdef VGA_SYNC_LINE_IRQ_EN
                639:      check("line_irq_before", 32'(s_int), 32'd0);
                640:      check("line_irq_set", 32'(s_int), 32'd1);
                701:      check("line_irq_cleared", 32'(s_int), 32'd0);
`endif
                4223:     check("vblank_irq_before", 32'(s_int), 32'd0);
                4224:     check("vblank_irq_set", 32'(s_int), 32'd1);
                4357:     check("irq_held", 32'(s_int), 32'd1);
                4358:     check("irq_cli_clear", 32'(s_int), 32'd0);
                FR + 4223: check("irq_stays_clear", 32'(s_int), 32'd0);
                FR + 4224: check("irq_next_frame", 32'(s_int), 32'd1);
                FR + 4400: check("frame_period", 32'(vs_second - vs_first), 32'(FR));
                F2 + 4210: check("collision_pre", 32'(s_int), 32'd0);
                F2 + 4224: check("collision_set_wins", 32'(s_int), 32'd1);
                F2 + 4235: check("collision_sticky", 32'(s_int), 32'd1);
                F2 + 4241: check("collision_later_cli", 32'(s_int), 32'd0);
                default: ;
            endcase

`ifdef VGA_SYNC_LINE_IRQ_EN
            if (k == 800) irq_line = 10'd900;
            cli = (k == 4357) || (k == 700) ||
                  (k >= F2 + 4200 && k <= F2 + 4223) || (k == F2 + 4240);
`else
            cli = (k == 4357) ||
                  (k >= F2 + 4200 && k <= F2 + 4223) || (k == F2 + 4240);
`endif
            @(negedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
